// File: rtl/streaming_argmax.sv
// ============================================================================
// streaming_argmax : running argmax over a multi-lane score stream | rev 1.0
// ============================================================================
`default_nettype none

module streaming_argmax #(
  parameter int N                = 8,
  parameter int NUM_LABELS       = 10,
  parameter int CLOG2_NUM_LABELS = 4,
  parameter int LANES            = 2,
  parameter int SIGNED           = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*N-1:0]          in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CLOG2_NUM_LABELS-1:0] out_label,
  output logic [N-1:0]                out_max
);

  localparam int BEATS = (NUM_LABELS + LANES - 1) / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t                      state_q;
  logic [CW-1:0]               beat_cnt_q;
  logic [N-1:0]                best_score_q, best_score_d, beat_score;
  logic [CLOG2_NUM_LABELS-1:0] best_label_q, best_label_d, beat_label;
  logic                        out_valid_q;
  logic [CLOG2_NUM_LABELS-1:0] out_label_q;
  logic [N-1:0]                out_max_q;

  function automatic logic gt(input logic [N-1:0] a, input logic [N-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  // Lane 0 always carries a real label; higher lanes may be padding on the last beat.
  always_comb begin : beat_winner
    int lbl;
    int win;
    lbl        = 0;
    win        = 0;
    beat_score = in_data[N-1:0];
    for (int k = 1; k < LANES; k++) begin
      lbl = int'(beat_cnt_q) * LANES + k;
      if (lbl < NUM_LABELS && gt(in_data[N*k +: N], beat_score)) begin
        beat_score = in_data[N*k +: N];
        win        = k;
      end
    end
    beat_label = CLOG2_NUM_LABELS'(int'(beat_cnt_q) * LANES + win);
  end

  always_comb begin
    best_score_d = best_score_q;
    best_label_d = best_label_q;
    if (beat_cnt_q == '0 || gt(beat_score, best_score_q)) begin
      best_score_d = beat_score;
      best_label_d = beat_label;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACC;
      beat_cnt_q   <= '0;
      best_score_q <= '0;
      best_label_q <= '0;
      out_valid_q  <= 1'b0;
      out_label_q  <= '0;
      out_max_q    <= '0;
    end else begin
      case (state_q)
        ACC: begin
          // A beat offered alongside flush is dropped.
          if (flush) begin
            beat_cnt_q   <= '0;
            best_score_q <= '0;
            best_label_q <= '0;
          end else if (in_valid) begin
            best_score_q <= best_score_d;
            best_label_q <= best_label_d;
            if (beat_cnt_q == LAST_BEAT) begin
              beat_cnt_q  <= '0;
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_label_q <= best_label_d;
              out_max_q   <= best_score_d;
            end else begin
              beat_cnt_q <= beat_cnt_q + CW'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ACC;
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

  assign in_ready  = (state_q == ACC) && !rst;
  assign out_valid = out_valid_q;
  assign out_label = out_label_q;
  assign out_max   = out_max_q;

endmodule

`default_nettype wire

// File: tb/tb_streaming_argmax.sv
// ============================================================================
// tb_streaming_argmax : scoreboard bench, unsigned 10x2 and signed 3x2 configs
// ============================================================================
`default_nettype none

module tb_streaming_argmax;

  typedef struct {
    logic [3:0] lbl;
    logic [7:0] mx;
  } res_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [15:0] in_data = '0;
  logic [3:0]  out_label;
  logic [7:0]  out_max;

  logic        s_in_valid = 1'b0, s_out_ready = 1'b1;
  logic        s_in_ready, s_out_valid;
  logic [15:0] s_in_data = '0;
  logic [1:0]  s_out_label;
  logic [7:0]  s_out_max;

  streaming_argmax dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_label(out_label), .out_max(out_max)
  );

  streaming_argmax #(.N(8), .NUM_LABELS(3), .CLOG2_NUM_LABELS(2), .LANES(2), .SIGNED(1)) sdut (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_label(s_out_label), .out_max(s_out_max)
  );

  int   tests = 0, fails = 0, acc_cnt = 0;
  res_t exp_q[$], sexp_q[$];
  res_t mr, smr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int val(input int s, input bit sgn);
    int v;
    v = s & 255;
    if (sgn && v > 127) v -= 256;
    return v;
  endfunction

  // Reference: first label holding the largest value.
  function automatic res_t model(input int sc[$], input bit sgn);
    res_t r;
    int   bi;
    bi = 0;
    foreach (sc[i]) if (val(sc[i], sgn) > val(sc[bi], sgn)) bi = i;
    r.lbl = 4'(bi);
    r.mx  = 8'(sc[bi]);
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && in_valid && in_ready && !flush) acc_cnt++;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_result: got label %0d max %0d, expected no result", out_label, out_max);
      end else begin
        mr = exp_q.pop_front();
        chk("label", 32'(out_label), 32'(mr.lbl));
        chk("max", 32'(out_max), 32'(mr.mx));
      end
    end
    if (s_out_valid && s_out_ready) begin
      if (sexp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL s_unexpected_result: got label %0d max %0d, expected no result", s_out_label, s_out_max);
      end else begin
        smr = sexp_q.pop_front();
        chk("s_label", 32'(s_out_label), 32'(smr.lbl));
        chk("s_max", 32'(s_out_max), 32'(smr.mx));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beats(input int sc[$], input int nb, input bit gaps);
    for (int b = 0; b < nb; b++) begin : beat
      int t;
      bit ok;
      if (gaps) repeat ($urandom_range(0, 3)) step();
      in_valid = 1'b1;
      in_data  = {8'(sc[2*b+1]), 8'(sc[2*b])};
      t  = 0;
      ok = 1'b0;
      while (!ok && t < 50) begin
        @(negedge clk);
        ok = in_ready;
        step();
        t++;
      end
      chk("beat_accept", 32'(ok), 32'd1);
      in_valid = 1'b0;
    end
  endtask

  task automatic send_vec(input int sc[$], input bit gaps);
    exp_q.push_back(model(sc, 1'b0));
    send_beats(sc, 5, gaps);
    @(negedge clk);
    chk("latency_valid", 32'(out_valid), 32'd1);
    step();
  endtask

  task automatic s_send(input int sc[$], input int pad);
    sexp_q.push_back(model(sc, 1'b1));
    for (int b = 0; b < 2; b++) begin : sbeat
      int t;
      bit ok;
      s_in_valid = 1'b1;
      s_in_data  = (b == 0) ? {8'(sc[1]), 8'(sc[0])} : {8'(pad), 8'(sc[2])};
      t  = 0;
      ok = 1'b0;
      while (!ok && t < 50) begin
        @(negedge clk);
        ok = s_in_ready;
        step();
        t++;
      end
      chk("s_beat_accept", 32'(ok), 32'd1);
      s_in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || sexp_q.size() != 0) && t < 100) begin
      step();
      t++;
    end
    chk("drain", 32'(exp_q.size() + sexp_q.size()), 32'd0);
  endtask

  task automatic check_cleared(input string tag);
    @(negedge clk);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_label"}, 32'(out_label), 32'd0);
    chk({tag, "_out_max"}, 32'(out_max), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    step();
  endtask

  function automatic void rand_vec(output int sc[$], input int lo, input int hi);
    sc = {};
    for (int i = 0; i < 10; i++) sc.push_back(int'($urandom_range(hi, lo)));
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stim
    int   sc[$];
    int   a;
    res_t r;

    // Reset behaviour
    step();
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    check_cleared("reset");

    // Directed unsigned vector with a tie between labels 1 and 4
    sc = '{3, 9, 1, 7, 9, 0, 2, 5, 4, 6};
    send_vec(sc, 1'b0);
    wait_drain();

    // Back-pressure: result held, input blocked
    rand_vec(sc, 0, 255);
    r = model(sc, 1'b0);
    out_ready = 1'b0;
    send_vec(sc, 1'b0);
    a = acc_cnt;
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    repeat (4) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_label", 32'(out_label), 32'(r.lbl));
      chk("bp_max", 32'(out_max), 32'(r.mx));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    chk("bp_no_accept", 32'(acc_cnt), 32'(a));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    step();
    wait_drain();

    // Flush mid-vector; the flushed beats and the dropped beat hold 250
    sc = '{250, 250, 250, 250, 250, 250, 250, 250, 250, 250};
    send_beats(sc, 2, 1'b0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = {8'd250, 8'd250};
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    rand_vec(sc, 0, 199);
    sc[8] = 200;
    send_vec(sc, 1'b0);
    wait_drain();

    // Flush while holding a result is ignored
    rand_vec(sc, 0, 255);
    out_ready = 1'b0;
    send_vec(sc, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_done_valid", 32'(out_valid), 32'd1);
    step();
    out_ready = 1'b1;
    wait_drain();

    // Reset mid-vector, after a result with a nonzero label
    sc = '{1, 2, 3, 4, 5, 6, 7, 90, 8, 9};
    send_vec(sc, 1'b0);
    wait_drain();
    send_beats(sc, 3, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_cleared("rst_mid");
    rand_vec(sc, 0, 255);
    send_vec(sc, 1'b0);
    wait_drain();

    // Reset while holding a result
    sc = '{1, 2, 3, 4, 5, 6, 7, 90, 8, 9};
    out_ready = 1'b0;
    send_vec(sc, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(exp_q.pop_back());
    check_cleared("rst_done");
    out_ready = 1'b1;
    rand_vec(sc, 0, 255);
    send_vec(sc, 1'b1);
    wait_drain();

    // Ascending scores with random input gaps
    sc = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    a = acc_cnt;
    send_vec(sc, 1'b1);
    chk("accept_count", 32'(acc_cnt - a), 32'd5);
    wait_drain();

    // Random vectors, tie-prone and full-range, with random output stalls
    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 1) rand_vec(sc, 0, 3);
      else rand_vec(sc, 0, 255);
      out_ready = 1'($urandom_range(0, 1));
      send_vec(sc, 1'b1);
      if (!out_ready) begin
        repeat ($urandom_range(0, 3)) step();
        out_ready = 1'b1;
      end
      wait_drain();
    end

    // Signed configuration: -5, -2, -9 with 0x7F in the padding lane
    sc = '{8'hFB, 8'hFE, 8'hF7};
    s_send(sc, 8'h7F);
    wait_drain();
    for (int i = 0; i < 15; i++) begin
      sc = '{0, 0, 0};
      foreach (sc[j]) sc[j] = int'($urandom_range(0, 255));
      s_send(sc, int'($urandom_range(0, 255)));
      wait_drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
